// File: rtl/mips_cache_writebuffer_pq_pkg.sv
// Shared types and helpers for the cache write buffer.
// Holds the drain FSM state type, the entry layout at default widths and
// the word-address helper used by the address comparators.
package mips_cache_pkg;

  localparam int WB_ADDR_W     = 32;
  localparam int WB_DATA_W     = 32;
  localparam int WB_BE_W       = WB_DATA_W / 8;
  // Widest address the word_addr helper handles; callers widen to this.
  localparam int WB_MAX_ADDR_W = 64;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_BE_W-1:0]   be;
  } wb_entry_t;

  // Strip the byte-within-word bits so that two byte addresses of the same
  // word compare equal.
  function automatic logic [WB_MAX_ADDR_W-1:0] word_addr(
    input logic [WB_MAX_ADDR_W-1:0] addr,
    input int unsigned              lsb
  );
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/mips_cache_writebuffer_pq_if.sv
// Push, lookup and Avalon write bus signals of the write buffer.
// The buffer itself connects through the slave modport; the cache/memory
// side (or a testbench) uses the master modport.
interface mips_cache_writebuffer_pq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [BE_W-1:0]   push_be;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic              active;
  logic              waitrequest;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   write_byteenable;
  logic              write_writeenable;

  modport slave (
    input  push_valid, push_addr, push_data, push_be, lookup_addr, active, waitrequest,
    output push_ready, lookup_hit, write_addr, write_data, write_byteenable, write_writeenable
  );

  modport master (
    output push_valid, push_addr, push_data, push_be, lookup_addr, active, waitrequest,
    input  push_ready, lookup_hit, write_addr, write_data, write_byteenable, write_writeenable
  );
endinterface

// File: rtl/mips_cache_wb_match.sv
// Word-address match over N buffer entries: one comparator per entry,
// qualified by the entry's valid bit, OR-reduced into a single hit.
module mips_cache_wb_match
  import mips_cache_pkg::*;
#(
  parameter int N      = 8,
  parameter int ADDR_W = 32,
  parameter int LSB    = 2
) (
  input  logic [N-1:0]             entry_valid,
  input  logic [N-1:0][ADDR_W-1:0] entry_addr,
  input  logic [ADDR_W-1:0]        key_addr,
  output logic                     hit
);

  logic [N-1:0]             hit_vec_s;
  logic [WB_MAX_ADDR_W-1:0] key_word_s;

  assign key_word_s = word_addr(WB_MAX_ADDR_W'(key_addr), LSB);

  // Per-entry comparison of word addresses.
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < N; i++) begin
      hit_vec_s[i] = entry_valid[i] &&
                     (word_addr(WB_MAX_ADDR_W'(entry_addr[i]), LSB) == key_word_s);
    end
  end

  assign hit = |hit_vec_s;

endmodule

// File: rtl/mips_cache_writebuffer_pq.sv
// Write buffer between the data cache and the Avalon memory master.
// Circular FIFO with count-based full/empty, a two-state drain FSM and a
// combinational lookup so the cache can stall reads that would overtake a
// pending store. Define MIPS_CACHE_WB_COALESCE_EN to merge a push into the
// youngest entry when both target the same word.
module mips_cache_writebuffer_pq
  import mips_cache_pkg::*;
#(
  parameter int DEPTH_BITS = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_cache_writebuffer_pq_if.slave   bus,
  output logic [DEPTH_BITS:0]          count,
  output logic                         full,
  output logic                         empty,
  output logic                         drained
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int BE_W  = DATA_W / 8;
  localparam int LSB   = $clog2(BE_W);

  wb_state_t                       state_q, state_d;
  logic [DEPTH_BITS-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]             count_q, count_d;
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]    addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0]    data_q, data_d;
  logic [DEPTH-1:0][BE_W-1:0]      be_q, be_d;

  logic              full_s, empty_s, pop_s, push_ready_s, push_fire_s;
  logic              alloc_s, coalesce_ok_s;
  logic [ADDR_W-1:0] push_word_s;

  assign full_s      = (count_q == (DEPTH_BITS + 1)'(DEPTH));
  assign empty_s     = (count_q == '0);
  assign pop_s       = (state_q == S_WRITE) && !bus.waitrequest;
  // Entries hold word-aligned addresses; the byte offset carries no meaning.
  assign push_word_s = bus.push_addr & ~(ADDR_W'(BE_W - 1));

`ifdef MIPS_CACHE_WB_COALESCE_EN
  logic [DEPTH_BITS-1:0] young_ptr_s;
  logic                  young_hit_s;
  logic                  merge_s;

  assign young_ptr_s = wr_ptr_q - DEPTH_BITS'(1);

  mips_cache_wb_match #(.N(1), .ADDR_W(ADDR_W), .LSB(LSB)) u_young_match (
    .entry_valid (valid_q[young_ptr_s]),
    .entry_addr  (addr_q[young_ptr_s]),
    .key_addr    (bus.push_addr),
    .hit         (young_hit_s)
  );

  // A merge into the head is unsafe while the bus is already showing it.
  assign coalesce_ok_s = young_hit_s && !((state_q == S_WRITE) && (young_ptr_s == rd_ptr_q));
  assign merge_s       = push_fire_s && coalesce_ok_s;
`else
  assign coalesce_ok_s = 1'b0;
`endif

  assign push_ready_s = !full_s || coalesce_ok_s;
  assign push_fire_s  = bus.push_valid && push_ready_s;
  assign alloc_s      = push_fire_s && !coalesce_ok_s;

  mips_cache_wb_match #(.N(DEPTH), .ADDR_W(ADDR_W), .LSB(LSB)) u_lookup_match (
    .entry_valid (valid_q),
    .entry_addr  (addr_q),
    .key_addr    (bus.lookup_addr),
    .hit         (bus.lookup_hit)
  );

  // Next FIFO contents, pointers and occupancy from push and pop.
  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + DEPTH_BITS'(1);
    end else begin
    end
    if (alloc_s) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = push_word_s;
      data_d[wr_ptr_q]  = bus.push_data;
      be_d[wr_ptr_q]    = bus.push_be;
      wr_ptr_d          = wr_ptr_q + DEPTH_BITS'(1);
    end else begin
    end
`ifdef MIPS_CACHE_WB_COALESCE_EN
    if (merge_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.push_be[b]) begin
          data_d[young_ptr_s][8*b +: 8] = bus.push_data[8*b +: 8];
        end else begin
          data_d[young_ptr_s][8*b +: 8] = data_q[young_ptr_s][8*b +: 8];
        end
      end
      be_d[young_ptr_s] = be_q[young_ptr_s] | bus.push_be;
    end else begin
    end
`endif
    case ({alloc_s, pop_s})
      2'b10:   count_d = count_q + (DEPTH_BITS + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM: start only with permission, hold a started write until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s && bus.active) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (pop_s) begin
          if ((count_q > (DEPTH_BITS + 1)'(1)) && bus.active) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pointer and storage registers; reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
    end
  end

  assign bus.push_ready        = push_ready_s;
  assign bus.write_writeenable = (state_q == S_WRITE);
  assign bus.write_addr        = addr_q[rd_ptr_q];
  assign bus.write_data        = data_q[rd_ptr_q];
  assign bus.write_byteenable  = be_q[rd_ptr_q];
  assign count                 = count_q;
  assign full                  = full_s;
  assign empty                 = empty_s;
  assign drained               = empty_s && (state_q == S_IDLE);

endmodule

// File: tb/tb_mips_cache_writebuffer_pq.sv
// Self-checking bench for mips_cache_writebuffer_pq: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_mips_cache_writebuffer_pq;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count;
  logic       full, empty, drained;

  always #5 clk = ~clk;

  mips_cache_writebuffer_pq_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mips_cache_writebuffer_pq #(.DEPTH_BITS(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .drained (drained)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];       // pending stores, oldest first
  bit          busy;        // a write is being presented on the bus
  logic [31:0] bus_log[$];  // addresses the bus accepted
  bit          last_acc;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wa(input logic [31:0] a);
    return a >> 2;
  endfunction

  function automatic bit m_merge_ok();
`ifdef MIPS_CACHE_WB_COALESCE_EN
    if (mq.size() == 0) return 1'b0;
    if (busy && mq.size() == 1) return 1'b0;
    return wa(bus_if.push_addr) == wa(mq[mq.size()-1].addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_hit();
    foreach (mq[i]) if (wa(mq[i].addr) == wa(bus_if.lookup_addr)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit   mok, rdy;
    int   old;
    ent_t e;
    #1;
    mok = m_merge_ok();
    rdy = (mq.size() < DEPTH) || mok;
    check_eq("count", count, mq.size());
    check_eq("full", full, mq.size() == DEPTH);
    check_eq("empty", empty, mq.size() == 0);
    check_eq("drained", drained, (mq.size() == 0) && !busy);
    check_eq("push_ready", bus_if.push_ready, rdy);
    check_eq("lookup_hit", bus_if.lookup_hit, m_hit());
    check_eq("wwe", bus_if.write_writeenable, busy);
    if (busy) begin
      check_eq("write_addr", bus_if.write_addr, mq[0].addr);
      check_eq("write_data", bus_if.write_data, mq[0].data);
      check_eq("write_be", bus_if.write_byteenable, mq[0].be);
    end
    if (bus_if.write_writeenable && !bus_if.waitrequest) bus_log.push_back(bus_if.write_addr);
    last_acc = bus_if.push_valid && rdy;
    @(posedge clk);
    old = mq.size();
    if (busy) begin
      if (!bus_if.waitrequest) begin
        busy = (old > 1) && bus_if.active;
        void'(mq.pop_front());
      end
    end else begin
      busy = (old > 0) && bus_if.active;
    end
    if (last_acc && mok) begin
      for (int b = 0; b < 4; b++)
        if (bus_if.push_be[b]) mq[mq.size()-1].data[8*b +: 8] = bus_if.push_data[8*b +: 8];
      mq[mq.size()-1].be = mq[mq.size()-1].be | bus_if.push_be;
    end else if (last_acc) begin
      e.addr = bus_if.push_addr & ~32'h3;
      e.data = bus_if.push_data;
      e.be   = bus_if.push_be;
      mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_if.push_valid = 1'b1;
    bus_if.push_addr  = a;
    bus_if.push_data  = d;
    bus_if.push_be    = be;
    cycle();
    bus_if.push_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int guard = 0;
    bus_if.push_valid  = 1'b0;
    bus_if.active      = 1'b1;
    bus_if.waitrequest = 1'b0;
    while ((mq.size() != 0 || busy) && guard < 60) begin
      cycle();
      guard++;
    end
    cycle();
    check_eq(tag, drained, 1'b1);
  endtask

  task automatic wait_wwe(input string tag);
    int guard = 0;
    while (!bus_if.write_writeenable && guard < 10) begin
      cycle();
      guard++;
    end
    check_eq(tag, bus_if.write_writeenable, 1'b1);
  endtask

  initial begin
    int k;
    int guard;
    bus_if.push_valid  = 1'b0;
    bus_if.push_addr   = 32'h0;
    bus_if.push_data   = 32'h0;
    bus_if.push_be     = 4'h0;
    bus_if.lookup_addr = 32'hFFFF_FF00;
    bus_if.active      = 1'b0;
    bus_if.waitrequest = 1'b1;
    busy = 1'b0;

    // Reset values.
    #2;
    check_eq("rst_wwe", bus_if.write_writeenable, 1'b0);
    check_eq("rst_ready", bus_if.push_ready, 1'b1);
    check_eq("rst_hit", bus_if.lookup_hit, 1'b0);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_drained", drained, 1'b1);
    check_eq("rst_count", count, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Fill, refuse at full, then wrap with four more pushes.
    bus_log.delete();
    bus_if.active      = 1'b1;
    bus_if.waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) push1(32'(i * 4), $urandom, 4'hF);
    bus_if.push_valid = 1'b1;
    bus_if.push_addr  = 32'h20;
    #1;
    check_eq("fill_full", full, 1'b1);
    check_eq("fill_ready", bus_if.push_ready, 1'b0);
    cycle();
    bus_if.waitrequest = 1'b0;
    k = 0;
    guard = 0;
    while (k < 4 && guard < 20) begin
      bus_if.push_valid = 1'b1;
      bus_if.push_addr  = 32'h20 + 32'(4 * k);
      bus_if.push_data  = $urandom;
      bus_if.push_be    = 4'hF;
      cycle();
      if (last_acc) k++;
      guard++;
    end
    check_eq("wrap_pushes", k, 4);
    drain_all("wrap_drained");
    check_eq("wrap_count", count, 4'd0);
    check_eq("wrap_log_len", bus_log.size(), 12);
    for (int i = 0; i < 12 && i < bus_log.size(); i++) check_eq("wrap_order", bus_log[i], 32'(i * 4));

    // A started write is held while active is low.
    bus_if.active      = 1'b1;
    bus_if.waitrequest = 1'b1;
    push1(32'h200, 32'h1111_2222, 4'hF);
    push1(32'h204, 32'h3333_4444, 4'hF);
    wait_wwe("hold_start");
    bus_if.active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("hold_wwe", bus_if.write_writeenable, 1'b1);
      check_eq("hold_addr", bus_if.write_addr, 32'h200);
      check_eq("hold_data", bus_if.write_data, 32'h1111_2222);
    end
    bus_if.waitrequest = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("hold_nostart", bus_if.write_writeenable, 1'b0);
      check_eq("hold_count", count, 4'd1);
    end
    drain_all("hold_drained");

    // Lookup against a pending entry, then after it drains.
    bus_if.active = 1'b0;
    push1(32'h40, 32'hCAFE_0040, 4'hF);
    bus_if.lookup_addr = 32'h42;
    #1;
    check_eq("lookup_hit42", bus_if.lookup_hit, 1'b1);
    bus_if.lookup_addr = 32'h44;
    #1;
    check_eq("lookup_miss44", bus_if.lookup_hit, 1'b0);
    cycle();
    drain_all("lookup_drained");
    bus_if.lookup_addr = 32'h42;
    #1;
    check_eq("lookup_after", bus_if.lookup_hit, 1'b0);
    cycle();

`ifdef MIPS_CACHE_WB_COALESCE_EN
    // Same-word pushes merge into one entry.
    bus_if.active = 1'b0;
    push1(32'h80, 32'h0000_00AA, 4'h1);
    push1(32'h80, 32'h0000_BB00, 4'h2);
    check_eq("coal_count", count, 4'd1);
    bus_if.active      = 1'b1;
    bus_if.waitrequest = 1'b1;
    wait_wwe("coal_start");
    check_eq("coal_data", bus_if.write_data, 32'h0000_BBAA);
    check_eq("coal_be", bus_if.write_byteenable, 4'h3);
    drain_all("coal_drained");

    // Merge accepted at full, new word refused.
    bus_if.active = 1'b0;
    for (int i = 0; i < 8; i++) push1(32'(i * 4), $urandom, 4'h1);
    bus_if.push_valid = 1'b1;
    bus_if.push_addr  = 32'h1C;
    bus_if.push_data  = 32'h0000_5500;
    bus_if.push_be    = 4'h2;
    #1;
    check_eq("coalfull_ready", bus_if.push_ready, 1'b1);
    cycle();
    check_eq("coalfull_count", count, 4'd8);
    bus_if.push_addr = 32'h20;
    #1;
    check_eq("coalfull_refuse", bus_if.push_ready, 1'b0);
    cycle();
    drain_all("coalfull_drained");
`endif

    // Reset while a write is held on the bus.
    bus_if.active      = 1'b1;
    bus_if.waitrequest = 1'b1;
    push1(32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_wwe("rstmid_start");
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_wwe", bus_if.write_writeenable, 1'b0);
    check_eq("rstmid_empty", empty, 1'b1);
    check_eq("rstmid_count", count, 4'd0);
    mq.delete();
    busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      bus_if.push_valid  = ($urandom_range(0, 99) < 60);
      bus_if.push_addr   = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      bus_if.push_data   = $urandom;
      bus_if.push_be     = 4'($urandom_range(0, 15));
      bus_if.lookup_addr = 32'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      bus_if.active      = ($urandom_range(0, 99) < 80);
      bus_if.waitrequest = ($urandom_range(0, 99) < 50);
      cycle();
    end
    drain_all("rand_drained");
    check_eq("final_count", count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cache_writebuffer_pq.md
Name: mips_cache_writebuffer_pq

Overview:
- Parametrised next-generation write buffer between the data cache and the Avalon memory master.
- Adds a valid/ready push handshake, which replaces edge-sensed write_en.
- Uses count-based full/empty and a power-of-two circular FIFO of any depth.
- Adds a combinational address-match lookup so the cache can stall reads that would bypass a pending store; optional same-word write coalescing.

Parameters:
- DEPTH_BITS, 3: log2 of entry count; DEPTH = 2**DEPTH_BITS, minimum 1.
- ADDR_W, 32: byte-address width.
- DATA_W, 32: data width, multiple of 8; BE_W = DATA_W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  cache presents a store.
- push_ready  out  1  buffer accepts the store this cycle.
- push_addr  in  ADDR_W  store byte address; low log2(BE_W) bits ignored.
- push_data  in  DATA_W  store data.
- push_be  in  BE_W  store byte enables.
- lookup_addr  in  ADDR_W  read address from cache.
- lookup_hit  out  1  some valid entry has the same word address.
- active  in  1  drain permission; low while a read miss owns the bus.
- waitrequest  in  1  Avalon slave stall.
- write_addr  out  ADDR_W  head entry address.
- write_data  out  DATA_W  head entry data.
- write_byteenable  out  BE_W  head entry enables.
- write_writeenable  out  1  Avalon write strobe.
- count  out  DEPTH_BITS+1  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- drained  out  1  empty and no write in flight.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and count go to 0; all entries invalid.
  - write_writeenable = 0, push_ready = 1, lookup_hit = 0, empty = 1, full = 0, drained = 1.
  - Reset asserted mid-transaction drops the write immediately; contents are discarded.
- Storage: circular FIFO with wr_ptr/rd_ptr of DEPTH_BITS bits that wrap naturally, plus a separate count register. Full/empty come from count, never from pointer equality.
- Push:
  - A transfer occurs on push_valid && push_ready at the clock edge.
  - push_ready = !full (coalescing can extend this; see Optional Feature).
  - Accepted data is visible on the write_* outputs no earlier than the next cycle.
  - push_valid held high for N cycles with push_ready high means N entries; no edge detection.
- Drain FSM, two states:
  - S_IDLE: write_writeenable = 0. Move to S_WRITE when !empty && active.
  - S_WRITE: write_writeenable = 1, and write_* show the head entry, stable.
  - On !waitrequest: pop the head (rd_ptr+1, count-1); return to S_IDLE, or stay in S_WRITE if count > 1 && active.
  - Once in S_WRITE, the transaction is held until accepted even if active falls. active gates only the start of a new write.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a push in the same cycle as a pop is still refused, because push_ready is derived from registered count.
- Wrap-around: DEPTH consecutive pushes then DEPTH pops must return data in order across the pointer wrap.
- lookup_hit is combinational. It compares lookup_addr[ADDR_W-1:log2(BE_W)] against every valid entry, including the in-flight head. The cache stalls its read while lookup_hit = 1.
- drained = empty && state == S_IDLE.

Optional Feature:
- Macro: MIPS_CACHE_WB_COALESCE_EN.
- Defined:
  - A push whose word address equals the youngest valid entry merges into that entry instead of allocating a new one.
  - Merge rule: bytes where push_be is set overwrite; be_new = be_old | push_be; count is unchanged.
  - Not allowed when the youngest entry is the head currently presented with write_writeenable = 1.
  - push_ready = !full || coalesce_ok, so a merge is accepted even when the buffer is full.
- Undefined: every push allocates a new entry; coalesce logic is absent.

Decomposition:
- Package mips_cache_pkg holds:
  - wb_state_t enum (S_IDLE, S_WRITE).
  - wb_entry_t packed struct (valid, addr, data, be), parametrised by localparams matching the defaults.
  - word_addr helper function.
- One sub-module, mips_cache_wb_match: per-entry word-address comparators plus an OR-reduce. Used for lookup_hit and, when coalescing is enabled, for the youngest-entry match.

Test Plan:
- Reset mid-write: push 0x100/0xDEADBEEF/0xF, hold waitrequest = 1, assert rst_n = 0 -> write_writeenable falls asynchronously; empty = 1, count = 0.
- Fill and wrap (DEPTH_BITS = 3): hold waitrequest = 1, push 8 stores to addresses 0x00..0x1C -> full = 1, push_ready = 0. Release waitrequest, then push 4 more -> all 12 appear on the bus in order; count returns to 0.
- Hold on active drop: with write_writeenable = 1, drop active and keep waitrequest = 1 for 3 cycles -> write_* stay stable. On waitrequest = 0 the entry pops and no new write starts until active = 1.
- Lookup: with entry 0x40 pending, lookup_addr = 0x42 -> lookup_hit = 1; lookup_addr = 0x44 -> lookup_hit = 0. After 0x40 drains, 0x42 -> lookup_hit = 0.
- Coalesce (macro on): active = 0; push 0x80/0x000000AA/0x1, then 0x80/0x0000BB00/0x2 -> count = 1; the bus later shows data 0x0000BBAA, be = 0x3.
- Coalesce at full (macro on): 8 entries pending, youngest 0x1C; push to 0x1C -> push_ready = 1 and the merge occurs. Push to 0x20 -> push_ready = 0.
